// File: rtl/axil_master_arbiter_if.sv
// AXI4-Lite bus bundle used between the requester arbiter and the interconnect.
// The master modport is the arbiter side and the slave modport is the interconnect/VIP side.
interface axil_master_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   AWADDR;
    logic [2:0]              AWPROT;
    logic                    AWVALID;
    logic                    AWREADY;
    logic [DATA_WIDTH-1:0]   WDATA;
    logic [DATA_WIDTH/8-1:0] WSTRB;
    logic                    WVALID;
    logic                    WREADY;
    logic [1:0]              BRESP;
    logic                    BVALID;
    logic                    BREADY;
    logic [ADDR_WIDTH-1:0]   ARADDR;
    logic [2:0]              ARPROT;
    logic                    ARVALID;
    logic                    ARREADY;
    logic [DATA_WIDTH-1:0]   RDATA;
    logic [1:0]              RRESP;
    logic                    RVALID;
    logic                    RREADY;

    modport master (
        output AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
               ARADDR, ARPROT, ARVALID, RREADY,
        input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );

    modport slave (
        input  AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
               ARADDR, ARPROT, ARVALID, RREADY,
        output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );
endinterface

// File: rtl/axil_master_arbiter.sv
// Round-robin arbiter that shares one AXI4-Lite master port among NUM_REQ single-beat requesters.
// A watchdog parks the block in STUCK with HUNG set if a transaction never completes.
module axil_master_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                          ACLK,
    input  logic                          ARESET,
    input  logic [NUM_REQ-1:0]            REQ_VALID,
    input  logic [NUM_REQ-1:0]            REQ_WRITE,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] REQ_ADDR,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_WDATA,
    input  logic [NUM_REQ*4-1:0]          REQ_WSTRB,
    output logic [NUM_REQ-1:0]            REQ_READY,
    output logic [NUM_REQ-1:0]            RSP_VALID,
    output logic [DATA_WIDTH-1:0]         RSP_RDATA,
    output logic                          RSP_ERR,
    axil_master_arbiter_if.master         M_AXI,
    output logic                          BUSY,
    output logic                          HUNG,
    output logic [7:0]                    ERR_COUNT
);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, WR, WR_RESP, RD, RD_DATA, RESP, STUCK} state_t;

    state_t                  state;
    logic [PW-1:0]           ptr;
    logic [NUM_REQ-1:0]      gnt;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [3:0]              wstrb_q;
    logic                    awvalid, wvalid, bready, arvalid, rready;
    logic [TW-1:0]           timer;

    logic                    found;
    logic [PW-1:0]           sel;
    logic [PW-1:0]           ptr_next;
    logic [NUM_REQ-1:0]      sel_onehot;
    logic                    in_flight;
    logic                    completing;
    logic                    timeout_hit;

    // Scan from the round-robin pointer upward with wrap-around; the first active requester wins.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int idx;
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && REQ_VALID[PW'(idx)]) begin
                found = 1'b1;
                sel   = PW'(idx);
            end
        end
    end

    assign ptr_next    = (sel == PW'(NUM_REQ - 1)) ? '0 : sel + PW'(1);
    assign sel_onehot  = NUM_REQ'(1) << sel;
    assign in_flight   = (state == WR) || (state == WR_RESP) || (state == RD) || (state == RD_DATA);
    assign completing  = ((state == WR_RESP) && M_AXI.BVALID) || ((state == RD_DATA) && M_AXI.RVALID);
    assign timeout_hit = (timer == TW'(TIMEOUT_CYCLES - 1));

    // Transaction sequencer; a late timeout check overrides any normal progress unless the response lands.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state     <= IDLE;
            ptr       <= '0;
            gnt       <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awvalid   <= 1'b0;
            wvalid    <= 1'b0;
            bready    <= 1'b0;
            arvalid   <= 1'b0;
            rready    <= 1'b0;
            timer     <= '0;
            REQ_READY <= '0;
            RSP_VALID <= '0;
            RSP_RDATA <= '0;
            RSP_ERR   <= 1'b0;
            HUNG      <= 1'b0;
            ERR_COUNT <= '0;
        end else begin
            REQ_READY <= '0;
            RSP_VALID <= '0;
            if (in_flight) timer <= timer + TW'(1);

            case (state)
                IDLE: begin
                    if (found) begin
                        REQ_READY <= sel_onehot;
                        gnt       <= sel_onehot;
                        ptr       <= ptr_next;
                        addr_q    <= REQ_ADDR[int'(sel)*ADDR_WIDTH +: ADDR_WIDTH];
                        wdata_q   <= REQ_WDATA[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
                        wstrb_q   <= REQ_WSTRB[int'(sel)*4 +: 4];
                        timer     <= '0;
                        if (REQ_WRITE[sel]) begin
                            awvalid <= 1'b1;
                            wvalid  <= 1'b1;
                            state   <= WR;
                        end else begin
                            arvalid <= 1'b1;
                            state   <= RD;
                        end
                    end
                end
                WR: begin
                    if (M_AXI.AWREADY) awvalid <= 1'b0;
                    if (M_AXI.WREADY)  wvalid  <= 1'b0;
                    if ((!awvalid || M_AXI.AWREADY) && (!wvalid || M_AXI.WREADY)) begin
                        bready <= 1'b1;
                        state  <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (M_AXI.BVALID) begin
                        bready    <= 1'b0;
                        RSP_VALID <= gnt;
                        RSP_ERR   <= M_AXI.BRESP[1];
                        RSP_RDATA <= '0;
                        if (M_AXI.BRESP[1] && (ERR_COUNT != 8'hFF)) ERR_COUNT <= ERR_COUNT + 8'd1;
                        state     <= RESP;
                    end
                end
                RD: begin
                    if (M_AXI.ARREADY) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (M_AXI.RVALID) begin
                        rready    <= 1'b0;
                        RSP_VALID <= gnt;
                        RSP_ERR   <= M_AXI.RRESP[1];
                        RSP_RDATA <= M_AXI.RDATA;
                        if (M_AXI.RRESP[1] && (ERR_COUNT != 8'hFF)) ERR_COUNT <= ERR_COUNT + 8'd1;
                        state     <= RESP;
                    end
                end
                RESP:    state <= IDLE;
                STUCK:   state <= STUCK;
                default: state <= IDLE;
            endcase

            if (in_flight && timeout_hit && !completing) begin
                awvalid   <= 1'b0;
                wvalid    <= 1'b0;
                bready    <= 1'b0;
                arvalid   <= 1'b0;
                rready    <= 1'b0;
                RSP_VALID <= gnt;
                RSP_ERR   <= 1'b1;
                RSP_RDATA <= '0;
                HUNG      <= 1'b1;
                state     <= STUCK;
            end
        end
    end

    assign BUSY          = (state != IDLE);
    assign M_AXI.AWADDR  = addr_q;
    assign M_AXI.AWPROT  = 3'b000;
    assign M_AXI.AWVALID = awvalid;
    assign M_AXI.WDATA   = wdata_q;
    assign M_AXI.WSTRB   = wstrb_q;
    assign M_AXI.WVALID  = wvalid;
    assign M_AXI.BREADY  = bready;
    assign M_AXI.ARADDR  = addr_q;
    assign M_AXI.ARPROT  = 3'b000;
    assign M_AXI.ARVALID = arvalid;
    assign M_AXI.RREADY  = rready;
endmodule

// File: tb/tb_axil_master_arbiter.sv
// Scoreboard bench for axil_master_arbiter: directed requests, a behavioural AXI4-Lite slave,
// and a monitor that pops expected grants/responses whenever the DUT pulses REQ_READY/RSP_VALID.
module tb_axil_master_arbiter;
    typedef struct packed {
        logic [3:0]  onehot;
        logic        err;
        logic [31:0] data;
    } rsp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   req_valid = '0;
    logic [3:0]   req_write = '0;
    logic [127:0] req_addr  = '0;
    logic [127:0] req_wdata = '0;
    logic [15:0]  req_wstrb = '0;
    logic [3:0]   REQ_READY, RSP_VALID;
    logic [31:0]  RSP_RDATA;
    logic         RSP_ERR, BUSY, HUNG;
    logic [7:0]   ERR_COUNT;

    axil_master_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) axi ();

    axil_master_arbiter #(
        .NUM_REQ(4), .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)
    ) dut (
        .ACLK(clk), .ARESET(rst),
        .REQ_VALID(req_valid), .REQ_WRITE(req_write), .REQ_ADDR(req_addr),
        .REQ_WDATA(req_wdata), .REQ_WSTRB(req_wstrb),
        .REQ_READY(REQ_READY), .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR),
        .M_AXI(axi), .BUSY(BUSY), .HUNG(HUNG), .ERR_COUNT(ERR_COUNT)
    );

    always #5 clk = ~clk;

    int   vectors = 0;
    int   miscompares = 0;
    int   gnt_q[$];
    rsp_t rsp_q[$];
    int   aw_hi = 0, w_hi = 0, ready_seen = 0;

    // Slave configuration, written by the main sequence
    int          aw_delay = 0;
    bit          ar_never = 0, b_hold = 0;
    logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
    logic [31:0] last_awaddr = '0, last_wdata = '0, last_araddr = '0;
    logic [3:0]  last_wstrb = '0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input int idx, input logic wr, input logic [31:0] addr,
                                 input logic [31:0] data, input logic [3:0] strb);
        req_write[idx]          = wr;
        req_addr[idx*32 +: 32]  = addr;
        req_wdata[idx*32 +: 32] = data;
        req_wstrb[idx*4 +: 4]   = strb;
        req_valid[idx]          = 1'b1;
    endtask

    task automatic expectTxn(input int idx, input logic err, input logic [31:0] data);
        rsp_t r;
        r.onehot = 4'(1) << idx;
        r.err    = err;
        r.data   = data;
        gnt_q.push_back(idx);
        rsp_q.push_back(r);
    endtask

    // Advance on negedges, counting valid levels and dropping requests once granted
    task automatic runCycles(input int n);
        repeat (n) begin
            @(negedge clk);
            if (axi.AWVALID) aw_hi++;
            if (axi.WVALID) w_hi++;
            if (REQ_READY != 0) ready_seen++;
            req_valid = req_valid & ~REQ_READY;
        end
    endtask

    task automatic waitIdle(input int budget);
        int n = 0;
        while ((rsp_q.size() != 0 || BUSY) && n < budget) begin
            runCycles(1);
            n++;
        end
        checkOutput("wait_idle", 64'(rsp_q.size() == 0 && !BUSY), 64'd1);
    endtask

    task automatic measureLatency(output int cyc, input int budget);
        cyc = 0;
        do begin
            runCycles(1);
            cyc++;
        end while (RSP_VALID == 0 && cyc < budget);
    endtask

    // Behavioural AXI4-Lite slave: decides READY/VALID at each negedge for the following rising edge
    initial begin
        logic [31:0] mem [64];
        bit aw_fire, w_fire, ar_fire, b_fire, r_fire, got_aw, got_w, pend_r;
        int aw_wait;
        foreach (mem[i]) mem[i] = '0;
        mem[8]  = 32'h1234_5678;
        mem[16] = 32'hCAFE_F00D;
        {aw_fire, w_fire, ar_fire, b_fire, r_fire, got_aw, got_w, pend_r} = '0;
        aw_wait = 0;
        {axi.AWREADY, axi.WREADY, axi.BVALID, axi.ARREADY, axi.RVALID} = '0;
        axi.BRESP = 2'b00; axi.RRESP = 2'b00; axi.RDATA = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                {aw_fire, w_fire, ar_fire, b_fire, r_fire, got_aw, got_w, pend_r} = '0;
                aw_wait = 0;
                {axi.AWREADY, axi.WREADY, axi.BVALID, axi.ARREADY, axi.RVALID} = '0;
                continue;
            end
            if (aw_fire) got_aw = 1;
            if (w_fire)  got_w  = 1;
            if (ar_fire) pend_r = 1;
            if (b_fire)  axi.BVALID = 1'b0;
            if (r_fire)  axi.RVALID = 1'b0;
            if (got_aw && got_w && !b_hold) begin
                axi.BVALID = 1'b1;
                axi.BRESP  = bresp_cfg;
                got_aw = 0;
                got_w  = 0;
            end
            if (pend_r) begin
                axi.RVALID = 1'b1;
                axi.RDATA  = mem[last_araddr[7:2]];
                axi.RRESP  = rresp_cfg;
                pend_r = 0;
            end
            if (axi.AWVALID) begin
                if (aw_wait >= aw_delay) axi.AWREADY = 1'b1;
                else begin
                    axi.AWREADY = 1'b0;
                    aw_wait++;
                end
            end else begin
                axi.AWREADY = 1'b0;
                aw_wait = 0;
            end
            axi.WREADY  = axi.WVALID;
            axi.ARREADY = axi.ARVALID && !ar_never;
            aw_fire = axi.AWVALID && axi.AWREADY;
            w_fire  = axi.WVALID && axi.WREADY;
            ar_fire = axi.ARVALID && axi.ARREADY;
            b_fire  = axi.BVALID && axi.BREADY;
            r_fire  = axi.RVALID && axi.RREADY;
            if (aw_fire) last_awaddr = axi.AWADDR;
            if (w_fire) begin
                last_wdata = axi.WDATA;
                last_wstrb = axi.WSTRB;
            end
            if (ar_fire) last_araddr = axi.ARADDR;
        end
    end

    // Monitor: every grant or completion pulse is checked against the head of its queue
    initial begin
        int   g;
        rsp_t r;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (REQ_READY != 0) begin
                    if (gnt_q.size() == 0) checkOutput("unexpected_grant", 64'(REQ_READY), 64'd0);
                    else begin
                        g = gnt_q.pop_front();
                        checkOutput("grant", 64'(REQ_READY), 64'(1) << g);
                    end
                end
                if (RSP_VALID != 0) begin
                    if (rsp_q.size() == 0) checkOutput("unexpected_rsp", 64'(RSP_VALID), 64'd0);
                    else begin
                        r = rsp_q.pop_front();
                        checkOutput("rsp_valid", 64'(RSP_VALID), 64'(r.onehot));
                        checkOutput("rsp_err", 64'(RSP_ERR), 64'(r.err));
                        checkOutput("rsp_rdata", 64'(RSP_RDATA), 64'(r.data));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int cyc, n;
        runCycles(3);
        checkOutput("reset_ready_rsp", 64'({REQ_READY, RSP_VALID}), 64'd0);
        checkOutput("reset_busy_hung", 64'({BUSY, HUNG}), 64'd0);
        checkOutput("reset_err_count", 64'(ERR_COUNT), 64'd0);
        checkOutput("reset_axi_valids",
                    64'({axi.AWVALID, axi.WVALID, axi.BREADY, axi.ARVALID, axi.RREADY}), 64'd0);
        rst = 1'b0;

        $display("[TB] single write from req0");
        applyStimulus(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF);
        expectTxn(0, 1'b0, 32'h0);
        measureLatency(cyc, 30);
        checkOutput("write_latency", 64'(cyc), 64'd3);
        waitIdle(30);
        checkOutput("awaddr", 64'(last_awaddr), 64'h10);
        checkOutput("wdata", 64'(last_wdata), 64'hDEAD_BEEF);
        checkOutput("wstrb", 64'(last_wstrb), 64'hF);
        checkOutput("err_count_ok", 64'(ERR_COUNT), 64'd0);

        $display("[TB] single read from req2");
        applyStimulus(2, 1'b0, 32'h0000_0020, 32'h0, 4'h0);
        expectTxn(2, 1'b0, 32'h1234_5678);
        measureLatency(cyc, 30);
        checkOutput("read_latency", 64'(cyc), 64'd3);
        waitIdle(30);
        checkOutput("araddr", 64'(last_araddr), 64'h20);

        // req3 alone brings the pointer back to 0
        applyStimulus(3, 1'b1, 32'h0000_0070, 32'h7777_7777, 4'h3);
        expectTxn(3, 1'b0, 32'h0);
        waitIdle(30);
        checkOutput("wstrb_partial", 64'(last_wstrb), 64'h3);

        $display("[TB] four simultaneous requests, pointer 0");
        applyStimulus(0, 1'b1, 32'h0000_0100, 32'hA0A0_A0A0, 4'hF);
        applyStimulus(1, 1'b0, 32'h0000_0020, 32'h0, 4'h0);
        applyStimulus(2, 1'b1, 32'h0000_0104, 32'hC2C2_C2C2, 4'hF);
        applyStimulus(3, 1'b0, 32'h0000_0040, 32'h0, 4'h0);
        expectTxn(0, 1'b0, 32'h0);
        expectTxn(1, 1'b0, 32'h1234_5678);
        expectTxn(2, 1'b0, 32'h0);
        expectTxn(3, 1'b0, 32'hCAFE_F00D);
        waitIdle(100);

        // req1 alone moves the pointer to 2
        applyStimulus(1, 1'b0, 32'h0000_0020, 32'h0, 4'h0);
        expectTxn(1, 1'b0, 32'h1234_5678);
        waitIdle(30);

        $display("[TB] four simultaneous requests, pointer 2");
        applyStimulus(0, 1'b1, 32'h0000_0100, 32'hA0A0_A0A0, 4'hF);
        applyStimulus(1, 1'b0, 32'h0000_0020, 32'h0, 4'h0);
        applyStimulus(2, 1'b1, 32'h0000_0104, 32'hC2C2_C2C2, 4'hF);
        applyStimulus(3, 1'b0, 32'h0000_0040, 32'h0, 4'h0);
        expectTxn(2, 1'b0, 32'h0);
        expectTxn(3, 1'b0, 32'hCAFE_F00D);
        expectTxn(0, 1'b0, 32'h0);
        expectTxn(1, 1'b0, 32'h1234_5678);
        waitIdle(100);

        $display("[TB] delayed AWREADY with SLVERR");
        aw_delay = 3;
        bresp_cfg = 2'b10;
        aw_hi = 0;
        w_hi = 0;
        applyStimulus(0, 1'b1, 32'h0000_0030, 32'h55AA_55AA, 4'hF);
        expectTxn(0, 1'b1, 32'h0);
        waitIdle(40);
        checkOutput("awvalid_cycles", 64'(aw_hi), 64'd4);
        checkOutput("wvalid_cycles", 64'(w_hi), 64'd1);
        checkOutput("err_count_slverr", 64'(ERR_COUNT), 64'd1);
        aw_delay = 0;
        bresp_cfg = 2'b00;

        $display("[TB] ARREADY never asserted");
        ar_never = 1;
        applyStimulus(3, 1'b0, 32'h0000_0044, 32'h0, 4'h0);
        expectTxn(3, 1'b1, 32'h0);
        measureLatency(cyc, 60);
        checkOutput("timeout_latency", 64'(cyc), 64'd17);
        runCycles(1);
        checkOutput("hung_set", 64'(HUNG), 64'd1);
        checkOutput("stuck_busy", 64'(BUSY), 64'd1);
        checkOutput("stuck_arvalid", 64'(axi.ARVALID), 64'd0);
        checkOutput("err_count_timeout", 64'(ERR_COUNT), 64'd1);
        applyStimulus(0, 1'b0, 32'h0000_0040, 32'h0, 4'h0);
        expectTxn(0, 1'b0, 32'hCAFE_F00D);
        ready_seen = 0;
        runCycles(10);
        checkOutput("stuck_no_grant", 64'(ready_seen), 64'd0);
        ar_never = 0;
        rst = 1'b1;
        runCycles(2);
        checkOutput("reset_clears_hung", 64'(HUNG), 64'd0);
        rst = 1'b0;
        waitIdle(30);

        $display("[TB] reset during WR_RESP");
        b_hold = 1;
        applyStimulus(1, 1'b1, 32'h0000_0050, 32'h1122_3344, 4'hF);
        gnt_q.push_back(1);
        n = 0;
        while (!axi.BREADY && n < 20) begin
            runCycles(1);
            n++;
        end
        checkOutput("reached_wr_resp", 64'(axi.BREADY), 64'd1);
        #1 rst = 1'b1;
        #1;
        checkOutput("async_reset_outputs",
                    64'({REQ_READY, RSP_VALID, BUSY, axi.AWVALID, axi.WVALID, axi.BREADY,
                         axi.ARVALID, axi.RREADY}), 64'd0);
        runCycles(2);
        rst = 1'b0;
        b_hold = 0;
        runCycles(5);
        checkOutput("abandoned_no_rsp", 64'(rsp_q.size() + gnt_q.size()), 64'd0);
        applyStimulus(2, 1'b1, 32'h0000_0060, 32'h0BAD_CAFE, 4'hF);
        expectTxn(2, 1'b0, 32'h0);
        measureLatency(cyc, 30);
        checkOutput("post_reset_latency", 64'(cyc), 64'd3);
        waitIdle(30);
        checkOutput("post_reset_awaddr", 64'(last_awaddr), 64'h60);
        checkOutput("post_reset_wdata", 64'(last_wdata), 64'h0BAD_CAFE);

        checkOutput("queues_drained", 64'(rsp_q.size() + gnt_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
